// File: rtl/ai_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ai_pkg
// Description : Shared types and elaboration-time helpers for the predictive
//               AI paddle: FSM state enum, playfield reflection bounds
//               (YL/YH), paddle prescaler limit and counter width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ai_pkg;

    typedef enum logic [2:0] {
        S_RETURN  = 3'd0,
        S_REACT   = 3'd1,
        S_PREDICT = 3'd2,
        S_TRACK   = 3'd3
    } ai_state_t;

    // Lowest legal ball-centre y (top wall reflection line).
    function automatic int yl_of(input int ball_size);
        return ball_size / 2;
    endfunction

    // Highest legal ball-centre y (bottom wall reflection line).
    function automatic int yh_of(input int v_video, input int ball_size);
        return v_video - ball_size / 2;
    endfunction

    // Clock cycles per 1px paddle step; never below 1.
    function automatic int unsigned psc_limit_of(input int unsigned clk_hz,
                                                 input int unsigned speed);
        int unsigned v;
        v = (speed == 0) ? clk_hz : clk_hz / speed;
        return (v == 0) ? 32'd1 : v;
    endfunction

    // Reaction delay in clock cycles; 64-bit product so real pixel clocks
    // with half-second delays do not overflow. Never below 1.
    function automatic int unsigned react_cycles_of(input int unsigned clk_hz,
                                                    input int unsigned ms);
        longint unsigned v;
        v = (64'(ms) * 64'(clk_hz)) / 64'd1000;
        return (v == 0) ? 32'd1 : 32'(v);
    endfunction

    // Width of a counter that runs 0 .. n-1.
    function automatic int cnt_width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int          c_yl_default        = yl_of(16);
    localparam int          c_yh_default        = yh_of(480, 16);
    localparam int unsigned c_psc_limit_default = psc_limit_of(25_175_000, 600);

endpackage : ai_pkg
`default_nettype wire

// File: rtl/ai_intercept_calc.sv
`default_nettype none
// ============================================================================
// Module      : ai_intercept_calc
// Description : Intercept prediction datapath. On i_start it snapshots the
//               ball, projects the centre to the paddle face along a 45-deg
//               path, then folds it back into the field with one wall
//               reflection per cycle (max 4, then clamp). Finally applies
//               the aim offset and clamps the paddle-centre target.
// Ports       : clk_0, rst       clock / sync active-high reset
//               i_en             0 freezes all state
//               i_flush          abort any calculation in flight
//               i_start          1-cycle request, samples ball/aim/offset
//               i_ball_x/y/ydir  ball top-left and vertical direction
//               i_aim_neg        1: subtract offset, 0: add
//               i_offset         aim error magnitude in px
//               o_done           1-cycle pulse, o_target valid
//               o_target         paddle-centre target y
// Revision    : 1.0 - initial release
// ============================================================================
module ai_intercept_calc
    import ai_pkg::*;
#(
    parameter int V_VIDEO       = 480,
    parameter int PDL_HEIGHT    = 96,
    parameter int BALL_SIZE     = 16,
    parameter int PADDLE_FACE_X = 608
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_flush,
    input  logic       i_start,
    input  logic [9:0] i_ball_x,
    input  logic [9:0] i_ball_y,
    input  logic       i_ydir,
    input  logic       i_aim_neg,
    input  logic [7:0] i_offset,
    output logic       o_done,
    output logic [9:0] o_target
);

    localparam logic signed [11:0] c_yl        = 12'(yl_of(BALL_SIZE));
    localparam logic signed [11:0] c_yh        = 12'(yh_of(V_VIDEO, BALL_SIZE));
    localparam logic signed [11:0] c_yl2       = 12'(2 * yl_of(BALL_SIZE));
    localparam logic signed [11:0] c_yh2       = 12'(2 * yh_of(V_VIDEO, BALL_SIZE));
    localparam logic signed [11:0] c_tmin      = 12'(PDL_HEIGHT / 2);
    localparam logic signed [11:0] c_tmax      = 12'(V_VIDEO - PDL_HEIGHT / 2);
    localparam logic signed [11:0] c_face      = 12'(PADDLE_FACE_X);
    localparam logic signed [11:0] c_half_ball = 12'(BALL_SIZE / 2);
    localparam logic [9:0]         c_tgt_rst   = 10'(V_VIDEO / 2);
    localparam logic [2:0]         c_max_iter  = 3'd4;

    logic signed [11:0] r_y;
    logic [2:0]         r_iter;
    logic               r_busy;
    logic               r_done;
    logic               r_aim_neg;
    logic [7:0]         r_offset;
    logic [9:0]         r_target;

    logic signed [11:0] w_cx, w_cy, w_dx, w_adx, w_y0;
    logic signed [11:0] w_refl, w_ylim, w_off, w_aimed, w_tgt;
    logic               w_hi, w_lo;

    always_comb begin
        w_cx  = $signed({2'b00, i_ball_x}) + c_half_ball;
        w_cy  = $signed({2'b00, i_ball_y}) + c_half_ball;
        w_dx  = c_face - w_cx;
        w_adx = w_dx[11] ? -w_dx : w_dx;
        // 45-degree travel: vertical distance equals horizontal distance.
        w_y0  = i_ydir ? (w_cy + w_adx) : (w_cy - w_adx);

        w_hi   = (r_y > c_yh);
        w_lo   = (r_y < c_yl);
        w_refl = w_hi ? (c_yh2 - r_y) : (c_yl2 - r_y);
        // Only differs from r_y when the iteration bound ran out.
        w_ylim = w_hi ? c_yh : (w_lo ? c_yl : r_y);

        w_off   = $signed({4'b0000, r_offset});
        w_aimed = r_aim_neg ? (w_ylim - w_off) : (w_ylim + w_off);
        if (w_aimed < c_tmin) begin
            w_tgt = c_tmin;
        end else if (w_aimed > c_tmax) begin
            w_tgt = c_tmax;
        end else begin
            w_tgt = w_aimed;
        end
    end

    always_ff @(posedge clk_0) begin
        if (rst) begin
            r_y       <= '0;
            r_iter    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aim_neg <= 1'b0;
            r_offset  <= '0;
            r_target  <= c_tgt_rst;
        end else if (i_flush) begin
            r_iter <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_en) begin
            r_done <= 1'b0;
            if (i_start) begin
                r_y       <= w_y0;
                r_iter    <= '0;
                r_busy    <= 1'b1;
                r_aim_neg <= i_aim_neg;
                r_offset  <= i_offset;
            end else if (r_busy) begin
                if ((!w_hi && !w_lo) || (r_iter == c_max_iter)) begin
                    r_target <= 10'(w_tgt);
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end else begin
                    r_y    <= w_refl;
                    r_iter <= r_iter + 3'd1;
                end
            end
        end
    end

    assign o_done   = r_done;
    assign o_target = r_target;

endmodule : ai_intercept_calc
`default_nettype wire

// File: rtl/ai_opponent_predictive.sv
`default_nettype none
// ============================================================================
// Module      : ai_opponent_predictive
// Description : CPU paddle for the Pong engine. Waits a reaction delay once
//               the ball approaches, predicts the wall-bounced intercept at
//               the paddle face, then steps the paddle 1px per prescaler
//               period toward it (or back to mid-screen between volleys).
// Config      : AI_REPREDICT_EN - when defined, a live ydir change in TRACK
//               reruns the prediction with a fresh snapshot (aim sign kept).
// Ports       : clk_0, rst               clock / sync active-high reset
//               ball_x, ball_y           ball top-left position
//               ball_xdir, ball_ydir     1 = right / 1 = down
//               reset_game               recentre paddle, abort volley
//               ball_missed              ball left the field
//               diff_mode                00 adaptive, 01 easy, 10 hard, 11 idle
//               score_p1, score_p2       player / AI score
//               ai_ypos                  paddle top y
//               predict_valid            intercept available this volley
//               ai_state                 FSM state for debug
// Revision    : 1.0 - initial release
// ============================================================================
module ai_opponent_predictive
    import ai_pkg::*;
#(
    parameter int CLK_HZ        = 25_175_000,
    parameter int V_VIDEO       = 480,
    parameter int PDL_HEIGHT    = 96,
    parameter int BALL_SIZE     = 16,
    parameter int PADDLE_FACE_X = 608,
    parameter int SIDE_RIGHT    = 1,
    parameter int SPEED         = 600,
    parameter int REACTION_MS   = 500,
    parameter int MIN_OFF       = 0,
    parameter int MAX_OFF       = 48,
    parameter int BASE_OFF      = 6,
    parameter int SCALE         = 3,
    parameter int SCORE_W       = 4
) (
    input  logic               clk_0,
    input  logic               rst,
    input  logic [9:0]         ball_x,
    input  logic [9:0]         ball_y,
    input  logic               ball_xdir,
    input  logic               ball_ydir,
    input  logic               reset_game,
    input  logic               ball_missed,
    input  logic [1:0]         diff_mode,
    input  logic [SCORE_W-1:0] score_p1,
    input  logic [SCORE_W-1:0] score_p2,
    output logic [9:0]         ai_ypos,
    output logic               predict_valid,
    output logic [2:0]         ai_state
);

    localparam int unsigned c_psc_limit = psc_limit_of(CLK_HZ, SPEED);
    localparam int unsigned c_react_cyc = react_cycles_of(CLK_HZ, REACTION_MS);
    localparam int          c_psc_w     = cnt_width_of(c_psc_limit);
    localparam int          c_react_w   = cnt_width_of(c_react_cyc);

    localparam logic [c_psc_w-1:0]   c_psc_last   = c_psc_w'(c_psc_limit - 1);
    localparam logic [c_react_w-1:0] c_react_last = c_react_w'(c_react_cyc - 1);
    localparam logic [9:0]           c_home_y     = 10'(V_VIDEO / 2 - PDL_HEIGHT / 2);
    localparam logic [9:0]           c_half_pdl   = 10'(PDL_HEIGHT / 2);
    localparam logic [9:0]           c_centre     = 10'(V_VIDEO / 2);
    localparam logic [9:0]           c_ymax       = 10'(V_VIDEO - PDL_HEIGHT);
    localparam logic                 c_side       = (SIDE_RIGHT != 0);
    localparam logic [5:0]           c_lfsr_seed  = 6'b000001;

    ai_state_t              r_state, w_next;
    logic [c_react_w-1:0]   r_react_cnt;
    logic [c_psc_w-1:0]     r_psc;
    logic [5:0]             r_lfsr;
    logic                   r_aim_neg;
    logic                   r_pred_start;
    logic                   r_pv;
    logic [9:0]             r_ypos;

    logic                   w_rst_any;
    logic                   w_run;
    logic                   w_approach;
    logic                   w_tick;
    logic [10:0]            w_centre;
    logic [9:0]             w_goal;
    logic                   w_move_en;
    logic                   w_calc_done;
    logic                   w_calc_flush;
    logic [9:0]             w_target;
    logic [7:0]             w_offset;
    logic [31:0]            w_sdiff, w_scaled, w_raw, w_adapt;

`ifdef AI_REPREDICT_EN
    logic                   r_ydir_prev;
`endif

    assign w_rst_any  = rst || reset_game;
    assign w_run      = (diff_mode != 2'b11);
    assign w_approach = (ball_xdir == c_side) && !ball_missed;
    assign w_tick     = (r_psc == c_psc_last);
    assign w_centre   = {1'b0, r_ypos} + {1'b0, c_half_pdl};

    // ---------------- aim error magnitude ----------------
    // Score gap is taken as a magnitude first, and the trailing-AI branch
    // saturates at zero, so nothing wraps regardless of score values.
    always_comb begin
        w_sdiff  = (score_p2 >= score_p1) ? 32'(score_p2 - score_p1)
                                          : 32'(score_p1 - score_p2);
        w_scaled = w_sdiff * 32'(SCALE);
        if (score_p2 > score_p1) begin
            w_raw = 32'(BASE_OFF) + w_scaled;
        end else if (score_p1 > score_p2) begin
            w_raw = (w_scaled >= 32'(BASE_OFF)) ? 32'd0 : (32'(BASE_OFF) - w_scaled);
        end else begin
            w_raw = 32'(BASE_OFF);
        end
        if (w_raw < 32'(MIN_OFF)) begin
            w_adapt = 32'(MIN_OFF);
        end else if (w_raw > 32'(MAX_OFF)) begin
            w_adapt = 32'(MAX_OFF);
        end else begin
            w_adapt = w_raw;
        end
        case (diff_mode)
            2'b01:   w_offset = 8'(MAX_OFF);
            2'b10:   w_offset = 8'(MIN_OFF);
            default: w_offset = 8'(w_adapt);
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_0) begin
        if (w_rst_any) begin
            r_state <= S_RETURN;
        end else if (w_run) begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        if (!w_approach) begin
            w_next = S_RETURN;
        end else begin
            case (r_state)
                S_RETURN:  w_next = S_REACT;
                S_REACT:   if (r_react_cnt == c_react_last) w_next = S_PREDICT;
                S_PREDICT: if (w_calc_done) w_next = S_TRACK;
                S_TRACK: begin
`ifdef AI_REPREDICT_EN
                    if (ball_ydir != r_ydir_prev) w_next = S_PREDICT;
`endif
                end
                default:   w_next = S_RETURN;
            endcase
        end
    end

    // ---------------- FSM: outputs (movement goal) ----------------
    always_comb begin
        w_goal    = c_centre;
        w_move_en = 1'b0;
        case (r_state)
            S_TRACK: begin
                w_goal    = w_target;
                w_move_en = 1'b1;
            end
            S_RETURN: begin
                w_goal    = c_centre;
                w_move_en = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- sequential datapath ----------------
    always_ff @(posedge clk_0) begin
        if (rst) begin
            r_lfsr <= c_lfsr_seed;
        end else begin
            r_lfsr <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
        end
    end

    always_ff @(posedge clk_0) begin
        if (w_rst_any) begin
            r_react_cnt  <= '0;
            r_psc        <= '0;
            r_aim_neg    <= 1'b0;
            r_pred_start <= 1'b0;
            r_pv         <= 1'b0;
            r_ypos       <= c_home_y;
        end else if (w_run) begin
            r_react_cnt <= ((r_state == S_REACT) && (w_next == S_REACT))
                           ? (r_react_cnt + c_react_w'(1)) : '0;
            // Prescaler free-runs across state changes so an aborted volley
            // keeps the step cadence.
            r_psc <= w_tick ? '0 : (r_psc + c_psc_w'(1));

            if ((r_state == S_RETURN) && (w_next == S_REACT)) begin
                r_aim_neg <= r_lfsr[5];
            end

            r_pred_start <= (w_next == S_PREDICT) && (r_state != S_PREDICT);

            if (w_next == S_RETURN) begin
                r_pv <= 1'b0;
            end else if ((r_state == S_PREDICT) && (w_next == S_TRACK)) begin
                r_pv <= 1'b1;
            end

            if (w_tick && w_move_en) begin
                if ((w_centre < {1'b0, w_goal}) && (r_ypos < c_ymax)) begin
                    r_ypos <= r_ypos + 10'd1;
                end else if ((w_centre > {1'b0, w_goal}) && (r_ypos != 10'd0)) begin
                    r_ypos <= r_ypos - 10'd1;
                end
            end
        end
    end

`ifdef AI_REPREDICT_EN
    always_ff @(posedge clk_0) begin
        if (w_rst_any) begin
            r_ydir_prev <= ball_ydir;
        end else if (w_run) begin
            r_ydir_prev <= ball_ydir;
        end
    end
`endif

    // The calculator is only live while PREDICT is current.
    assign w_calc_flush = w_rst_any || (r_state != S_PREDICT);

    ai_intercept_calc #(
        .V_VIDEO       (V_VIDEO),
        .PDL_HEIGHT    (PDL_HEIGHT),
        .BALL_SIZE     (BALL_SIZE),
        .PADDLE_FACE_X (PADDLE_FACE_X)
    ) u_calc (
        .clk_0     (clk_0),
        .rst       (rst),
        .i_en      (w_run),
        .i_flush   (w_calc_flush),
        .i_start   (r_pred_start),
        .i_ball_x  (ball_x),
        .i_ball_y  (ball_y),
        .i_ydir    (ball_ydir),
        .i_aim_neg (r_aim_neg),
        .i_offset  (w_offset),
        .o_done    (w_calc_done),
        .o_target  (w_target)
    );

    assign ai_ypos       = r_ypos;
    assign predict_valid = r_pv;
    assign ai_state      = r_state;

endmodule : ai_opponent_predictive
`default_nettype wire

// File: tb/tb_ai_opponent_predictive.sv
`default_nettype none
// ============================================================================
// Module      : tb_ai_opponent_predictive
// Description : Self-checking bench for ai_opponent_predictive with a fast
//               clock configuration (PSC 10, reaction 10 cycles). Expected
//               paddle positions come from a behavioural intercept model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ai_opponent_predictive;

    localparam int c_yl   = 8;
    localparam int c_yh   = 472;
    localparam int c_face = 608;
    localparam int c_tmin = 48;
    localparam int c_tmax = 432;
    localparam int c_home = 192;

    logic       clk_0 = 1'b0;
    logic       rst, reset_game, ball_xdir, ball_ydir, ball_missed;
    logic [9:0] ball_x, ball_y;
    logic [1:0] diff_mode;
    logic [3:0] score_p1, score_p2;
    logic [9:0] ai_ypos;
    logic       predict_valid;
    logic [2:0] ai_state;

    int checks = 0;
    int errors = 0;

    always #5 clk_0 = ~clk_0;

    ai_opponent_predictive #(
        .CLK_HZ      (1000),
        .SPEED       (100),
        .REACTION_MS (10)
    ) dut (
        .clk_0         (clk_0),
        .rst           (rst),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .ball_xdir     (ball_xdir),
        .ball_ydir     (ball_ydir),
        .reset_game    (reset_game),
        .ball_missed   (ball_missed),
        .diff_mode     (diff_mode),
        .score_p1      (score_p1),
        .score_p2      (score_p2),
        .ai_ypos       (ai_ypos),
        .predict_valid (predict_valid),
        .ai_state      (ai_state)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ball-centre y where the ball reaches the paddle face, walls folded in.
    function automatic int model_intercept(input int bx, input int by, input bit yd);
        int cx, cy, d, y;
        cx = bx + 8;
        cy = by + 8;
        d  = c_face - cx;
        if (d < 0) d = -d;
        y = yd ? cy + d : cy - d;
        for (int i = 0; i < 4; i++) begin
            if (y > c_yh)      y = 2 * c_yh - y;
            else if (y < c_yl) y = 2 * c_yl - y;
        end
        if (y > c_yh) y = c_yh;
        if (y < c_yl) y = c_yl;
        return y;
    endfunction

    // Expected resting paddle top for a zero-offset prediction.
    function automatic int model_rest(input int bx, input int by, input bit yd);
        int t;
        t = model_intercept(bx, by, yd);
        if (t < c_tmin) t = c_tmin;
        if (t > c_tmax) t = c_tmax;
        return t - 48;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_0);
        #1;
    endtask

    task automatic start_volley(input int bx, input int by, input bit yd, output int lat);
        ball_xdir  = 1'b0;
        reset_game = 1'b1;
        tick(1);
        reset_game = 1'b0;
        ball_x     = 10'(bx);
        ball_y     = 10'(by);
        ball_ydir  = yd;
        ball_xdir  = 1'b1;
        lat = 0;
        while (!predict_valid && lat < 60) begin
            tick(1);
            lat++;
        end
        if (!predict_valid) check_val("pv_timeout", predict_valid, 1);
    endtask

    task automatic settle(input int exp_y, input int extra_px);
        tick((iabs(exp_y - c_home) + extra_px + 3) * 10);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, y0, y1, exp_y, bx, by;
        bit yd;
        rst = 1'b1; reset_game = 1'b0; ball_xdir = 1'b0; ball_ydir = 1'b0;
        ball_missed = 1'b0; ball_x = '0; ball_y = '0; diff_mode = 2'b10;
        score_p1 = '0; score_p2 = '0;
        tick(3);
        check_val("rst_ypos", ai_ypos, c_home);
        check_val("rst_pv", predict_valid, 0);
        check_val("rst_state", ai_state, 0);
        rst = 1'b0;
        tick(20);
        check_val("idle_ypos", ai_ypos, c_home);

        // Straight intercept, no reflection.
        start_volley(392, 92, 1'b1, lat);
        check_val("pv_latency", (lat >= 11 && lat <= 16), 1);
        check_val("track_state", ai_state, 3);
        exp_y = model_rest(392, 92, 1'b1);
        settle(exp_y, 0);
        check_val("v_down_ypos", ai_ypos, exp_y);

        // Bottom wall reflection.
        start_volley(392, 392, 1'b1, lat);
        exp_y = model_rest(392, 392, 1'b1);
        settle(exp_y, 0);
        check_val("v_bottom_ypos", ai_ypos, exp_y);

        // Top wall reflection.
        start_volley(392, 92, 1'b0, lat);
        exp_y = model_rest(392, 92, 1'b0);
        settle(exp_y, 0);
        check_val("v_top_ypos", ai_ypos, exp_y);

        // Direction flip while tracking: back to RETURN, 1px per 10 cycles.
        ball_xdir = 1'b0;
        tick(2);
        check_val("abort_state", ai_state, 0);
        check_val("abort_pv", predict_valid, 0);
        y0 = ai_ypos;
        tick(10);
        y1 = ai_ypos;
        check_val("return_step", y1 - y0, 1);
        tick((c_home - y1 + 5) * 10);
        check_val("return_centre", ai_ypos, c_home);

        // Adaptive aim error, AI leading 9-0.
        score_p2 = 4'd9; score_p1 = 4'd0; diff_mode = 2'b00;
        start_volley(392, 92, 1'b1, lat);
        settle(model_rest(392, 92, 1'b1), 33);
        check_val("off_adaptive", iabs(int'(ai_ypos) + 48 - model_intercept(392, 92, 1'b1)), 33);

        diff_mode = 2'b01;
        start_volley(392, 92, 1'b1, lat);
        settle(model_rest(392, 92, 1'b1), 48);
        check_val("off_easy", iabs(int'(ai_ypos) + 48 - model_intercept(392, 92, 1'b1)), 48);

        diff_mode = 2'b10;
        start_volley(392, 92, 1'b1, lat);
        exp_y = model_rest(392, 92, 1'b1);
        settle(exp_y, 0);
        check_val("off_hard", ai_ypos, exp_y);

        score_p2 = 4'd0; score_p1 = 4'd5; diff_mode = 2'b00;
        start_volley(392, 92, 1'b1, lat);
        settle(exp_y, 0);
        check_val("off_p1_lead", ai_ypos, exp_y);
        score_p1 = 4'd0; diff_mode = 2'b10;

        // Ball missed drops the volley.
        ball_missed = 1'b1;
        tick(2);
        check_val("missed_pv", predict_valid, 0);
        check_val("missed_state", ai_state, 0);
        ball_missed = 1'b0;

        // Idle mode freezes the paddle mid-move.
        start_volley(392, 392, 1'b1, lat);
        tick(200);
        diff_mode = 2'b11;
        tick(1);
        y0 = ai_ypos;
        tick(100);
        check_val("idle_hold_ypos", ai_ypos, y0);
        check_val("idle_hold_state", ai_state, 3);
        diff_mode = 2'b10;
        exp_y = model_rest(392, 392, 1'b1);
        settle(exp_y, 0);
        check_val("idle_resume_ypos", ai_ypos, exp_y);

        // Live ydir change while tracking.
        start_volley(392, 92, 1'b1, lat);
        exp_y = model_rest(392, 92, 1'b1);
        settle(exp_y, 0);
        ball_y    = 10'd392;
        ball_ydir = 1'b0;
`ifdef AI_REPREDICT_EN
        y1 = model_rest(392, 392, 1'b0);
`else
        y1 = exp_y;
`endif
        tick((iabs(exp_y - model_rest(392, 392, 1'b0)) + 5) * 10);
        check_val("repredict_ypos", ai_ypos, y1);

        // Randomised volleys, zero offset.
        for (int k = 0; k < 8; k++) begin
            bx = int'($urandom_range(590, 0));
            by = int'($urandom_range(464, 0));
            yd = 1'($urandom_range(1, 0));
            start_volley(bx, by, yd, lat);
            exp_y = model_rest(bx, by, yd);
            settle(exp_y, 0);
            check_val($sformatf("rand%0d_ypos", k), ai_ypos, exp_y);
        end

        // Reset in the middle of a volley.
        start_volley(392, 392, 1'b1, lat);
        tick(300);
        rst = 1'b1;
        tick(1);
        check_val("midrst_ypos", ai_ypos, c_home);
        check_val("midrst_state", ai_state, 0);
        check_val("midrst_pv", predict_valid, 0);
        rst = 1'b0;
        ball_xdir = 1'b0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ai_opponent_predictive
`default_nettype wire
